// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the fetch-stage branch predictor.
//   - predictor state encoding (INIT clears tables, RUN predicts/trains)
//   - counter init/allocate constants as functions of counter width
//   - PC index/tag slicing helpers (PC is passed zero-extended to 64 bits)
package bp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Weakly not-taken; for a 1-bit counter this is 0.
    function automatic int cnt_init_val(input int cnt_bits);
        return (1 << (cnt_bits - 1)) - 1;
    endfunction

    // Weakly taken; for a 1-bit counter this is 1.
    function automatic int cnt_alloc_val(input int cnt_bits);
        return 1 << (cnt_bits - 1);
    endfunction

    // Word-aligned PCs: drop bits [1:0], keep idx_bits above them.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_bits);
        return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_bits,
                                           input int tag_bits);
        return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// bp_sat_cnt: combinational next value of a W-bit saturating up/down counter.
// Ports:
//   cnt  in   W  current counter value
//   inc  in   1  1 = count up (taken), 0 = count down (not taken)
//   nxt  out  W  next value, clamped at all-ones and zero
module bp_sat_cnt
    import bp_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt,
    input  logic         inc,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != '1) nxt = cnt + W'(1);
        end else begin
            if (cnt != '0) nxt = cnt - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: fetch-stage predictor, tagged direct-mapped BTB with
// per-entry saturating counters. Lookup is combinational on pc_f; execute
// trains the tables with resolved outcomes.
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// the counter index (BTB tag/target remain indexed by PC only).
// Ports:
//   clk, rst (async, active low)
//   pc_f -> hit_f, pred_taken_f, pred_target_f        fetch lookup
//   upd_valid_x, upd_is_jmp_x, upd_pc_x, upd_taken_x,
//   upd_target_x, upd_mispred_x                       execute training
//   ready        tables cleared, predictor live
//   mispred_cnt  saturating count of flushed control-flow instructions
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int AWIDTH   = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 10,
    parameter int CNT_BITS = 2,
    parameter int GHR_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_f,
    output logic              hit_f,
    output logic              pred_taken_f,
    output logic [AWIDTH-1:0] pred_target_f,
    input  logic              upd_valid_x,
    input  logic              upd_is_jmp_x,
    input  logic [AWIDTH-1:0] upd_pc_x,
    input  logic              upd_taken_x,
    input  logic [AWIDTH-1:0] upd_target_x,
    input  logic              upd_mispred_x,
    output logic              ready,
    output logic [15:0]       mispred_cnt
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_INIT  = CNT_BITS'(cnt_init_val(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(cnt_alloc_val(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    // Elaboration-time parameter sanity.
    if ((1 << IDX) != ENTRIES || ENTRIES < 4) begin : g_bad_entries
        $error("ENTRIES must be a power of 2 and >= 4");
    end
    if (CNT_BITS < 1 || CNT_BITS > 4) begin : g_bad_cnt
        $error("CNT_BITS must be 1..4");
    end
    if (GHR_BITS < 1 || GHR_BITS > IDX) begin : g_bad_ghr
        $error("GHR_BITS must be 1..log2(ENTRIES)");
    end
    if (AWIDTH < IDX + TAG_BITS + 2 || AWIDTH > 64) begin : g_bad_aw
        $error("AWIDTH too small for index+tag, or above 64");
    end

    bp_state_e      state;
    logic [IDX-1:0] init_idx;

    // Tables have no reset: INIT sweeps them one entry per cycle.
    logic                valid_tab  [ENTRIES];
    logic [TAG_BITS-1:0] tag_tab    [ENTRIES];
    logic [AWIDTH-1:0]   target_tab [ENTRIES];
    logic [CNT_BITS-1:0] cnt_tab    [ENTRIES];

    logic [IDX-1:0]      idx_f, cidx_f, idx_x, cidx_x;
    logic [TAG_BITS-1:0] tag_f, tag_x;
    logic                hit_x;
    logic [CNT_BITS-1:0] cnt_nxt;

    assign idx_f = IDX'(pc_index(64'(pc_f), IDX));
    assign tag_f = TAG_BITS'(pc_tag(64'(pc_f), IDX, TAG_BITS));
    assign idx_x = IDX'(pc_index(64'(upd_pc_x), IDX));
    assign tag_x = TAG_BITS'(pc_tag(64'(upd_pc_x), IDX, TAG_BITS));

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    // Update path uses ghr before this update's shift, matching what fetch saw.
    assign cidx_f = idx_f ^ IDX'(ghr);
    assign cidx_x = idx_x ^ IDX'(ghr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (state == ST_RUN && upd_valid_x && !upd_is_jmp_x) begin
            ghr <= GHR_BITS'({ghr, upd_taken_x});
        end
    end
`else
    assign cidx_f = idx_f;
    assign cidx_x = idx_x;
`endif

    // Lookup: masked off entirely until the tables have been swept.
    assign hit_f         = (state == ST_RUN) && valid_tab[idx_f] && (tag_tab[idx_f] == tag_f);
    assign pred_taken_f  = hit_f && cnt_tab[cidx_f][CNT_BITS-1];
    assign pred_target_f = pred_taken_f ? target_tab[idx_f] : pc_f + AWIDTH'(4);

    assign hit_x = valid_tab[idx_x] && (tag_tab[idx_x] == tag_x);

    bp_sat_cnt #(.W(CNT_BITS)) u_sat_cnt (
        .cnt (cnt_tab[cidx_x]),
        .inc (upd_taken_x),
        .nxt (cnt_nxt)
    );

    // Table writes; reads above are combinational, so a same-cycle lookup
    // sees the pre-update contents.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            valid_tab[init_idx] <= 1'b0;
            cnt_tab[init_idx]   <= CNT_INIT;
        end else if (upd_valid_x) begin
            if (upd_is_jmp_x) begin
                valid_tab[idx_x]  <= 1'b1;
                tag_tab[idx_x]    <= tag_x;
                target_tab[idx_x] <= upd_target_x;
                cnt_tab[cidx_x]   <= CNT_MAX;
            end else if (hit_x) begin
                cnt_tab[cidx_x] <= cnt_nxt;
                if (upd_taken_x) target_tab[idx_x] <= upd_target_x;
            end else if (upd_taken_x) begin
                valid_tab[idx_x]  <= 1'b1;
                tag_tab[idx_x]    <= tag_x;
                target_tab[idx_x] <= upd_target_x;
                cnt_tab[cidx_x]   <= CNT_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_INIT;
            init_idx    <= '0;
            ready       <= 1'b0;
            mispred_cnt <= '0;
        end else begin
            // Counted in every state, including INIT.
            if (upd_valid_x && upd_mispred_x && mispred_cnt != 16'hFFFF)
                mispred_cnt <= mispred_cnt + 16'd1;
            if (state == ST_INIT) begin
                init_idx <= init_idx + IDX'(1);
                if (init_idx == IDX'(ENTRIES - 1)) begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
            end
        end
    end

endmodule
